// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, translates through the MMU, issues one
// instruction-SRAM read at a time and hands {pc, inst, excode} to decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hbfc0_0000,
    parameter logic [4:0]  ADEL_CODE = 5'h04,
    parameter logic [4:0]  NO_EX     = 5'h1f
) (
    input  logic        clk,
    input  logic        reset,

    output logic [31:0] fs_vaddr,
    input  logic [31:0] mmu_paddr,
    input  logic [4:0]  mmu_excode,

    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,

    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,

    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic [4:0]  fs_excode
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic        pending;

    logic        mapped;
    logic [4:0]  fetch_ex;
    logic        accept;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        mapped = !(pc[31] && (pc[30:28] <= 3'b100));
        if (pc[1:0] != 2'b00) begin
            fetch_ex = ADEL_CODE;
        end else if (mapped && (mmu_excode != NO_EX)) begin
            fetch_ex = mmu_excode;
        end else begin
            fetch_ex = NO_EX;
        end
    end

    assign fs_vaddr       = pc;
    assign inst_sram_wr   = 1'b0;
    assign inst_sram_size = 2'd2;
    assign inst_sram_addr = mmu_paddr;
    assign inst_sram_req  = !reset && (state == S_REQ) && (fetch_ex == NO_EX);
    assign accept         = inst_sram_req && inst_sram_addr_ok;

    // NOTE: state is updated with non-blocking assignments so every branch reads the
    // pre-edge values; the redirect capture below relies on its later write winning.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            redir_pc       <= '0;
            pending        <= 1'b0;
            fs_to_ds_valid <= 1'b0;
            fs_pc          <= RESET_PC;
            fs_inst        <= '0;
            fs_excode      <= NO_EX;
        end else if (flush) begin
            pc             <= flush_pc;
            pending        <= 1'b0;
            fs_to_ds_valid <= 1'b0;
            // An accepted or still-outstanding read must be drained before refetching.
            case (state)
                S_REQ:    state <= accept ? S_CANCEL : S_REQ;
                S_WAIT:   state <= inst_sram_data_ok ? S_REQ : S_CANCEL;
                S_HOLD:   state <= S_REQ;
                S_CANCEL: state <= inst_sram_data_ok ? S_REQ : S_CANCEL;
                default:  state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (fetch_ex != NO_EX) begin
                        fs_pc          <= pc;
                        fs_inst        <= '0;
                        fs_excode      <= fetch_ex;
                        fs_to_ds_valid <= 1'b1;
                        state          <= S_HOLD;
                    end else if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        fs_pc          <= pc;
                        fs_inst        <= inst_sram_rdata;
                        fs_excode      <= NO_EX;
                        fs_to_ds_valid <= 1'b1;
                        state          <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ds_allowin) begin
                        pc             <= pending ? redir_pc : pc + 32'd4;
                        pending        <= 1'b0;
                        fs_to_ds_valid <= 1'b0;
                        state          <= S_REQ;
                    end
                end
                S_CANCEL: begin
                    if (inst_sram_data_ok) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // A branch arriving on the handoff edge becomes the pending redirect for the next slot.
            if (br_taken) begin
                pending  <= 1'b1;
                redir_pc <= br_target;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized handshakes,
// checked every cycle against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
    localparam logic [4:0]  ADEL_CODE = 5'h04;
    localparam logic [4:0]  NO_EX     = 5'h1f;
    localparam logic [4:0]  TLBL      = 5'h02;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fs_vaddr;
    logic [31:0] mmu_paddr;
    logic [4:0]  mmu_excode;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        ds_allowin = 1'b0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic [4:0]  fs_excode;

    bit force_tlbl;
    int errors = 0;
    int checks = 0;

    // Reference model of the fetch stream
    logic [31:0] exp_pc;
    logic [31:0] redir;
    bit          pending;
    bit          exp_valid;
    logic [31:0] exp_inst;
    logic [4:0]  exp_exc;
    // Memory-side bookkeeping
    bit          outstanding;
    bit          live;
    int          age;
    logic [31:0] out_pa;
    bit          req_prev;
    int          dok_min_age = 2;
    logic [31:0] acc_q[$];
    logic [31:0] ho_q[$];

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .fs_vaddr          (fs_vaddr),
        .mmu_paddr         (mmu_paddr),
        .mmu_excode        (mmu_excode),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst),
        .fs_excode         (fs_excode)
    );

    function automatic bit is_unmapped(input logic [31:0] va);
        return (va >= 32'h8000_0000) && (va < 32'hd000_0000);
    endfunction

    function automatic logic [31:0] mmu_pa(input logic [31:0] va);
        return is_unmapped(va) ? va : (va ^ 32'h4000_0000);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pa);
        return {pa[15:0], pa[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [4:0] exp_ex(input logic [31:0] va);
        if ((va % 4) != 0) return ADEL_CODE;
        if (is_unmapped(va)) return NO_EX;
        return (force_tlbl || va[22]) ? TLBL : NO_EX;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        off = 32'($urandom_range(0, 31)) << 2;
        case ($urandom_range(0, 7))
            0: return 32'hbfc0_0380 + off;
            1: return 32'h8000_0000 + off;
            2: return 32'h0040_0000 + off;
            3: return 32'h0000_1000 + off;
            4: return 32'hc040_0000 + off;
            5: return 32'hd040_0000 + off;
            6: return 32'h8000_0002 + off;
            default: return 32'hffff_fff8;
        endcase
    endfunction

    assign mmu_paddr  = mmu_pa(fs_vaddr);
    assign mmu_excode = (force_tlbl || fs_vaddr[22]) ? TLBL : NO_EX;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input bit f, input logic [31:0] fpc, input bit b, input logic [31:0] bt,
                        input bit allow, input bit aok, input bit dok);
        bit         dv, acc, handoff, req_cycle;
        logic [4:0] ex_now;
        if (outstanding) age++;
        dv = dok && outstanding && (age >= dok_min_age);
        flush             = f;
        flush_pc          = fpc;
        br_taken          = b;
        br_target         = bt;
        ds_allowin        = allow;
        inst_sram_addr_ok = aok && !outstanding;
        inst_sram_data_ok = dv;
        inst_sram_rdata   = dv ? mem_word(out_pa) : $urandom;
        #1;
        ex_now    = exp_ex(exp_pc);
        req_cycle = !outstanding && !exp_valid;
        check("vaddr", fs_vaddr, exp_pc);
        check("req", 32'(inst_sram_req), 32'(req_cycle && (ex_now == NO_EX)));
        check("wr", 32'(inst_sram_wr), 32'd0);
        check("size", 32'(inst_sram_size), 32'd2);
        if (inst_sram_req) check("addr", inst_sram_addr, mmu_pa(exp_pc));
        check("valid", 32'(fs_to_ds_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("fs_pc", fs_pc, exp_pc);
            check("fs_inst", fs_inst, exp_inst);
            check("fs_excode", 32'(fs_excode), 32'(exp_exc));
        end

        acc     = inst_sram_req && inst_sram_addr_ok;
        handoff = exp_valid && allow && !f;
        if (acc) acc_q.push_back(inst_sram_addr);
        if (handoff) ho_q.push_back(fs_pc);

        if (f) begin
            exp_pc    = fpc;
            pending   = 1'b0;
            exp_valid = 1'b0;
            if (acc) begin
                outstanding = 1'b1; live = 1'b0; age = 0; out_pa = inst_sram_addr;
            end else if (dv) begin
                outstanding = 1'b0;
            end else begin
                live = 1'b0;
            end
        end else begin
            if (dv) begin
                outstanding = 1'b0;
                if (live) begin
                    exp_valid = 1'b1;
                    exp_inst  = mem_word(mmu_pa(exp_pc));
                    exp_exc   = NO_EX;
                end
            end else if (acc) begin
                outstanding = 1'b1; live = 1'b1; age = 0; out_pa = inst_sram_addr;
            end else if (req_cycle && (ex_now != NO_EX)) begin
                exp_valid = 1'b1;
                exp_inst  = '0;
                exp_exc   = ex_now;
            end
            if (handoff) begin
                exp_valid = 1'b0;
                exp_pc    = pending ? redir : exp_pc + 32'd4;
                pending   = 1'b0;
            end
            if (b) begin
                pending = 1'b1;
                redir   = bt;
            end
        end
        req_prev = inst_sram_req;
        @(posedge clk);
        @(negedge clk);
    endtask

    // addr_ok one cycle after req rises, data_ok no earlier than dok_min_age cycles after accept.
    task automatic late_step(input bit allow);
        step(1'b0, '0, 1'b0, '0, allow, inst_sram_req && req_prev, 1'b1);
    endtask

    task automatic wait_acc(input string tag, input bit allow);
        int n0 = acc_q.size();
        for (int i = 0; i < 12 && acc_q.size() == n0; i++) late_step(allow);
        check(tag, 32'(acc_q.size() > n0), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 12 && !fs_to_ds_valid; i++) late_step(1'b0);
        check(tag, 32'(fs_to_ds_valid), 32'd1);
    endtask

    initial begin
        int n_acc;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(inst_sram_req), 32'd0);
        check("rst_valid", 32'(fs_to_ds_valid), 32'd0);
        check("rst_inst", fs_inst, 32'd0);
        check("rst_excode", 32'(fs_excode), 32'(NO_EX));
        check("rst_vaddr", fs_vaddr, RESET_PC);
        reset     = 1'b0;
        exp_pc    = RESET_PC;
        pending   = 1'b0;
        exp_valid = 1'b0;

        // Sequential fetch with one-cycle-late handshakes and decode always ready
        wait_acc("a_acc0", 1'b1);
        check("a_addr0", acc_q[$], 32'hbfc0_0000);
        wait_acc("a_acc1", 1'b1);
        check("a_addr1", acc_q[$], 32'hbfc0_0004);
        wait_acc("a_acc2", 1'b1);
        check("a_addr2", acc_q[$], 32'hbfc0_0008);
        check("a_ho0", ho_q[0], 32'hbfc0_0000);

        // Mapped address with a TLB refill: no request, exception bundle
        step(1'b1, 32'h0040_0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_acc = acc_q.size();
        wait_valid("b_valid");
        check("b_excode", 32'(fs_excode), 32'(TLBL));
        check("b_inst", fs_inst, 32'd0);
        check("b_noreq", 32'(acc_q.size()), 32'(n_acc));
        late_step(1'b1);

        // Unmapped address ignores the MMU excode
        force_tlbl = 1'b1;
        step(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        wait_acc("c_acc", 1'b0);
        check("c_addr", acc_q[$], 32'h8000_0000);
        wait_valid("c_valid");
        check("c_excode", 32'(fs_excode), 32'(NO_EX));
        check("c_inst", fs_inst, mem_word(32'h8000_0000));
        force_tlbl = 1'b0;

        // Flush while waiting for data: the late word is dropped
        late_step(1'b1);
        wait_acc("d_acc", 1'b0);
        step(1'b1, 32'hbfc0_0380, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("d_novalid", 32'(fs_to_ds_valid), 32'd0);
        wait_acc("d_acc2", 1'b0);
        check("d_addr", acc_q[$], 32'hbfc0_0380);

        // Branch during a fetch, decode stalled four cycles, redirect at handoff
        step(1'b1, 32'h8000_0010, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        wait_acc("e_acc", 1'b0);
        check("e_addr", acc_q[$], 32'h8000_0010);
        step(1'b0, '0, 1'b1, 32'h8000_1000, 1'b0, 1'b0, 1'b0);
        wait_valid("e_valid");
        repeat (4) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("e_hold_pc", fs_pc, 32'h8000_0010);
        check("e_hold_inst", fs_inst, mem_word(32'h8000_0010));
        late_step(1'b1);
        check("e_redir", fs_vaddr, 32'h8000_1000);
        wait_acc("e_acc2", 1'b0);
        check("e_addr2", acc_q[$], 32'h8000_1000);

        // Flush and branch together: flush wins, no redirect left pending
        wait_valid("f_valid0");
        step(1'b1, 32'hbfc0_0380, 1'b1, 32'h8000_2000, 1'b0, 1'b0, 1'b0);
        wait_valid("f_valid");
        check("f_pc", fs_pc, 32'hbfc0_0380);
        late_step(1'b1);
        check("f_next", fs_vaddr, 32'hbfc0_0384);

        // PC wraps through the top of the address space
        step(1'b1, 32'hffff_fff8, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        wait_valid("g_valid");
        check("g_excode", 32'(fs_excode), 32'(TLBL));
        late_step(1'b1);
        wait_valid("g_valid2");
        late_step(1'b1);
        check("g_wrap", fs_vaddr, 32'h0000_0000);

        // Randomized handshakes, flushes and branches
        dok_min_age = 1;
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 19) == 0, rand_addr(),
                 $urandom_range(0, 9) == 0, rand_addr(),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end
        check("progress", 32'(ho_q.size() > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
